eth_f_packet_client_csr_pkt_cnt_mc: RTL and testbench

- Multi-channel statistics extender in the packet-client CSR path. Each channel takes a narrow, free-running packet counter (IN_W bits) from the client datapath plus an update strobe.
- Each channel accumulates the true count into an OUT_W-bit register using modular delta arithmetic. This replaces MSB-wrap detection, so any advance below 2^IN_W between updates is counted exactly.
- Adds per-channel clear, a coherent all-channel snapshot for CSR reads, and sticky overflow or saturation at OUT_W.

---
 rtl/eth_f_packet_client_csr_pkt_cnt_mc.sv | 117 +++++++++++
 tb/tb_eth_f_packet_client_csr_pkt_cnt_mc.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_f_packet_client_csr_pkt_cnt_mc.sv
// Per-channel extension of narrow free-running packet counters into wide accumulators.
// Modular delta accumulation, per-channel clear, coherent snapshot, sticky wrap/saturate flag.
module eth_f_packet_client_csr_pkt_cnt_mc #(
  parameter int NUM_CH   = 4,
  parameter int IN_W     = 8,
  parameter int OUT_W    = 64,
  parameter int SATURATE = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       cnt_in_vld,
  input  logic [NUM_CH*IN_W-1:0]  cnt_in,
  input  logic [NUM_CH-1:0]       cnt_clr,
  input  logic                    snap_req,
  output logic                    snap_done,
  output logic [NUM_CH*OUT_W-1:0] cnt_out,
  output logic [NUM_CH-1:0]       cnt_wrap
);

  logic [NUM_CH-1:0] meta_q, meta_d, sync_q, sync_d, dly_q, dly_d, prev_q, prev_d;
  logic [NUM_CH-1:0] armed_q, armed_d, upd_q, upd_d, clr_q, clr_d, wrap_q, wrap_d;
  logic [1:0]        fill_q, fill_d;
  logic              snap_done_q, snap_done_d;

  logic [OUT_W-1:0]  acc_q  [NUM_CH];
  logic [OUT_W-1:0]  acc_d  [NUM_CH];
  logic [OUT_W-1:0]  out_q  [NUM_CH];
  logic [OUT_W-1:0]  out_d  [NUM_CH];
  logic [IN_W-1:0]   last_q [NUM_CH];
  logic [IN_W-1:0]   last_d [NUM_CH];
  logic [IN_W-1:0]   delta  [NUM_CH];
  logic [OUT_W:0]    sum    [NUM_CH];

  always_comb begin
    meta_d      = cnt_in_vld;
    sync_d      = meta_q;
    dly_d       = sync_q;
    prev_d      = dly_q;
    clr_d       = cnt_clr;
    snap_done_d = snap_req;
    fill_d      = (fill_q == 2'd3) ? fill_q : fill_q + 2'd1;
    // Edges are only accepted once dly_q has been seen low on a post-reset sample,
    // so a vld level that straddles reset does not count as a new sample.
    armed_d     = armed_q | ({NUM_CH{fill_q == 2'd3}} & ~dly_q);
    upd_d       = dly_q & ~prev_q & armed_q;
    wrap_d      = wrap_q;

    for (int c = 0; c < NUM_CH; c++) begin
      // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
      acc_d[c]  = acc_q[c];
      last_d[c] = last_q[c];
      out_d[c]  = snap_req ? acc_q[c] : out_q[c];
      delta[c]  = cnt_in[c*IN_W +: IN_W] - last_q[c];
      sum[c]    = {1'b0, acc_q[c]} + {{(OUT_W + 1 - IN_W){1'b0}}, delta[c]};

      if (cnt_clr[c] || clr_q[c]) begin
        acc_d[c]  = '0;
        last_d[c] = '0;
        wrap_d[c] = 1'b0;
      end else if (upd_q[c]) begin
        last_d[c] = cnt_in[c*IN_W +: IN_W];
        if (sum[c][OUT_W]) begin
          wrap_d[c] = 1'b1;
          acc_d[c]  = (SATURATE != 0) ? {OUT_W{1'b1}} : sum[c][OUT_W-1:0];
        end else begin
          acc_d[c]  = sum[c][OUT_W-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state is written with non-blocking assignments only, so all flops see pre-edge values.
    if (rst) begin
      meta_q      <= '0;
      sync_q      <= '0;
      dly_q       <= '0;
      prev_q      <= '0;
      armed_q     <= '0;
      upd_q       <= '0;
      clr_q       <= '0;
      wrap_q      <= '0;
      fill_q      <= '0;
      snap_done_q <= 1'b0;
      // NOTE: these per-channel arrays are real registers with defined reset values, not RAM.
      for (int c = 0; c < NUM_CH; c++) begin
        acc_q[c]  <= '0;
        out_q[c]  <= '0;
        last_q[c] <= '0;
      end
    end else begin
      meta_q      <= meta_d;
      sync_q      <= sync_d;
      dly_q       <= dly_d;
      prev_q      <= prev_d;
      armed_q     <= armed_d;
      upd_q       <= upd_d;
      clr_q       <= clr_d;
      wrap_q      <= wrap_d;
      fill_q      <= fill_d;
      snap_done_q <= snap_done_d;
      for (int c = 0; c < NUM_CH; c++) begin
        acc_q[c]  <= acc_d[c];
        out_q[c]  <= out_d[c];
        last_q[c] <= last_d[c];
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_out
    assign cnt_out[g*OUT_W +: OUT_W] = out_q[g];
  end

  assign cnt_wrap  = wrap_q;
  assign snap_done = snap_done_q;

endmodule

// File: tb/tb_eth_f_packet_client_csr_pkt_cnt_mc.sv
// Scoreboard bench: main 4-channel instance plus two 16-bit instances for wrap/saturate.
module tb_eth_f_packet_client_csr_pkt_cnt_mc;

  typedef logic [4*64-1:0] snap_t;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   vld, clr;
  logic [31:0]  cin;
  logic         snap_req;
  logic         snap_done;
  logic [255:0] cnt_out;
  logic [3:0]   cnt_wrap;

  logic         s_vld, s_clr, s_snap;
  logic [7:0]   s_in;
  logic         s_done0, s_done1;
  logic [15:0]  s_out0, s_out1;
  logic         s_wrap0, s_wrap1;

  int    n_checks = 0;
  int    n_fail   = 0;
  snap_t sb_q[$];
  logic [63:0] exp_acc  [4];
  logic [7:0]  exp_last [4];

  always #5 clk = ~clk;

  eth_f_packet_client_csr_pkt_cnt_mc dut (
    .clk(clk), .rst(rst), .cnt_in_vld(vld), .cnt_in(cin), .cnt_clr(clr),
    .snap_req(snap_req), .snap_done(snap_done), .cnt_out(cnt_out), .cnt_wrap(cnt_wrap)
  );

  eth_f_packet_client_csr_pkt_cnt_mc #(.NUM_CH(1), .IN_W(8), .OUT_W(16), .SATURATE(0)) dut_wrap (
    .clk(clk), .rst(rst), .cnt_in_vld(s_vld), .cnt_in(s_in), .cnt_clr(s_clr),
    .snap_req(s_snap), .snap_done(s_done0), .cnt_out(s_out0), .cnt_wrap(s_wrap0)
  );

  eth_f_packet_client_csr_pkt_cnt_mc #(.NUM_CH(1), .IN_W(8), .OUT_W(16), .SATURATE(1)) dut_sat (
    .clk(clk), .rst(rst), .cnt_in_vld(s_vld), .cnt_in(s_in), .cnt_clr(s_clr),
    .snap_req(s_snap), .snap_done(s_done1), .cnt_out(s_out1), .cnt_wrap(s_wrap1)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int c = 0; c < 4; c++) begin
      exp_acc[c]  = '0;
      exp_last[c] = '0;
    end
  endtask

  task automatic push_snap();
    snap_t e;
    for (int c = 0; c < 4; c++) e[c*64 +: 64] = exp_acc[c];
    sb_q.push_back(e);
  endtask

  // Rise of vld is first sampled one edge after it is driven; the update lands 4 edges later.
  task automatic sample(input int ch, input logic [7:0] val, input bit clr_hit, input bit snap_hit);
    logic [7:0] d;
    cin[ch*8 +: 8] = val;
    vld[ch] = 1'b1;
    repeat (4) tick();
    if (snap_hit) begin
      push_snap();
      snap_req = 1'b1;
    end
    if (clr_hit) clr[ch] = 1'b1;
    tick();
    snap_req = 1'b0;
    clr[ch]  = 1'b0;
    if (clr_hit) begin
      exp_acc[ch]  = '0;
      exp_last[ch] = '0;
    end else begin
      d = val - exp_last[ch];
      exp_acc[ch]  = exp_acc[ch] + {56'd0, d};
      exp_last[ch] = val;
    end
    repeat (2) tick();
    vld[ch] = 1'b0;
    repeat (4) tick();
  endtask

  task automatic do_snap();
    push_snap();
    snap_req = 1'b1;
    tick();
    snap_req = 1'b0;
    check("snap_done_rise", {63'd0, snap_done}, 64'd1);
    tick();
    check("snap_done_fall", {63'd0, snap_done}, 64'd0);
  endtask

  task automatic s_sample(input logic [7:0] v);
    s_in  = v;
    s_vld = 1'b1;
    repeat (5) tick();
    s_vld = 1'b0;
    repeat (4) tick();
  endtask

  task automatic s_do_snap();
    s_snap = 1'b1;
    tick();
    s_snap = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst && snap_done) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_snap", 64'd1, 64'd0);
      end else begin
        snap_t e;
        e = sb_q.pop_front();
        for (int c = 0; c < 4; c++)
          check($sformatf("cnt_out%0d", c), cnt_out[c*64 +: 64], e[c*64 +: 64]);
      end
    end
  end

  initial begin
    logic [7:0] v;
    rst = 1'b1; vld = '0; clr = '0; cin = '0; snap_req = 1'b0;
    s_vld = 1'b0; s_clr = 1'b0; s_snap = 1'b0; s_in = '0;
    model_reset();
    repeat (3) tick();
    rst = 1'b0;
    check("rst_cnt_out", {63'd0, |cnt_out}, 64'd0);
    check("rst_cnt_wrap", {60'd0, cnt_wrap}, 64'd0);
    check("rst_snap_done", {63'd0, snap_done}, 64'd0);
    check("rst_s_out", {32'd0, s_out0, s_out1}, 64'd0);
    repeat (4) tick();

    // Basic count on ch0, then IN_W wrap on ch1
    sample(0, 8'h05, 1'b0, 1'b0);
    sample(0, 8'h0C, 1'b0, 1'b0);
    do_snap();
    sample(1, 8'hF0, 1'b0, 1'b0);
    sample(1, 8'h10, 1'b0, 1'b0);
    do_snap();
    check("wrap_after_inw_wrap", {60'd0, cnt_wrap}, 64'd0);

    // Clear coincident with update discards the sample and zeroes last
    sample(2, 8'h40, 1'b0, 1'b0);
    sample(2, 8'h50, 1'b1, 1'b0);
    do_snap();
    sample(2, 8'h03, 1'b0, 1'b0);
    do_snap();

    // Snapshot coincident with update captures the pre-update value
    sample(0, 8'h20, 1'b0, 1'b1);
    do_snap();

    // Back-to-back snapshots
    push_snap();
    push_snap();
    snap_req = 1'b1;
    tick();
    check("b2b_done_1", {63'd0, snap_done}, 64'd1);
    tick();
    snap_req = 1'b0;
    check("b2b_done_2", {63'd0, snap_done}, 64'd1);
    tick();
    check("b2b_done_fall", {63'd0, snap_done}, 64'd0);

    // vld held high 20 clk: one update only, later source changes ignored
    cin[24 +: 8] = 8'h07;
    vld[3] = 1'b1;
    repeat (8) tick();
    exp_acc[3]  = exp_acc[3] + 64'd7;
    exp_last[3] = 8'h07;
    cin[24 +: 8] = 8'h09;
    repeat (6) tick();
    do_snap();
    repeat (4) tick();
    vld[3] = 1'b0;
    repeat (4) tick();
    do_snap();
    check("wrap_main", {60'd0, cnt_wrap}, 64'd0);

    // 16-bit instances: preload to 0xFFF0, then add 0x20
    v = 8'h00;
    for (int i = 0; i < 256; i++) begin
      v = v + 8'hFF;
      s_sample(v);
    end
    v = v + 8'hF0;
    s_sample(v);
    s_do_snap();
    check("preload_wrap_mode", {48'd0, s_out0}, 64'h0000_0000_0000_FFF0);
    check("preload_sat_mode", {48'd0, s_out1}, 64'h0000_0000_0000_FFF0);
    check("preload_flags", {62'd0, s_wrap0, s_wrap1}, 64'd0);
    check("s_snap_done", {62'd0, s_done0, s_done1}, 64'd3);
    v = v + 8'h20;
    s_sample(v);
    s_do_snap();
    check("ovf_wrap_mode", {48'd0, s_out0}, 64'h0000_0000_0000_0010);
    check("ovf_sat_mode", {48'd0, s_out1}, 64'h0000_0000_0000_FFFF);
    check("ovf_flags", {62'd0, s_wrap0, s_wrap1}, 64'd3);
    v = v + 8'h05;
    s_sample(v);
    s_do_snap();
    check("post_ovf_wrap_mode", {48'd0, s_out0}, 64'h0000_0000_0000_0015);
    check("post_ovf_sat_hold", {48'd0, s_out1}, 64'h0000_0000_0000_FFFF);
    s_clr = 1'b1;
    tick();
    s_clr = 1'b0;
    repeat (2) tick();
    s_do_snap();
    check("clr_out", {32'd0, s_out0, s_out1}, 64'd0);
    check("clr_flags", {62'd0, s_wrap0, s_wrap1}, 64'd0);

    // Reset 2 clk after a vld rise: update dropped, held vld ignored until it re-rises
    check("sb_empty_pre_rst", 64'(sb_q.size()), 64'd0);
    cin[0 +: 8] = 8'h55;
    vld[0] = 1'b1;
    repeat (2) tick();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    model_reset();
    check("rst2_cnt_out", {63'd0, |cnt_out}, 64'd0);
    check("rst2_cnt_wrap", {60'd0, cnt_wrap}, 64'd0);
    check("rst2_snap_done", {63'd0, snap_done}, 64'd0);
    repeat (10) tick();
    do_snap();
    vld[0] = 1'b0;
    repeat (4) tick();
    sample(0, 8'h22, 1'b0, 1'b0);
    do_snap();

    repeat (3) tick();
    check("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
